// File: rtl/div_pkg.sv
// Shared definitions for the 64/32 restoring divider: default widths and FSM encoding.
package div_pkg;

  localparam int N_W_DEF   = 64;
  localparam int D_W_DEF   = 32;
  localparam int CNT_W_DEF = $clog2(N_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, conditionally subtract the divisor.
module div_step #(
  parameter int D_W = 32
) (
  input  logic [D_W:0]   rem_in,
  input  logic           bit_in,
  input  logic [D_W-1:0] divisor,
  output logic [D_W:0]   rem_out,
  output logic           q_bit
);

  logic [D_W:0] shifted_s;
  logic [D_W:0] diff_s;
  logic         ge_s;

  // A set MSB in the incoming remainder means the shifted value already exceeds any divisor.
  always_comb begin
    shifted_s = {rem_in[D_W-1:0], bit_in};
    diff_s    = shifted_s - {1'b0, divisor};
    ge_s      = rem_in[D_W] | (shifted_s >= {1'b0, divisor});
    if (ge_s) begin
      rem_out = diff_s;
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted_s;
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/div_64_32.sv
// Sequential radix-2 restoring divider, 64-bit dividend by 32-bit divisor, one quotient bit per clock.
// Optional build macro DIV_EARLY_TERM_EN: finish in one cycle when dividend < divisor.
module div_64_32
  import div_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_by_zero
);

  localparam int CNT_W = $clog2(N_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_W - 1);

  state_t           state_q, state_d;
  logic [N_W-1:0]   dividend_q, dividend_d;
  logic [D_W-1:0]   divisor_q, divisor_d;
  logic [D_W:0]     rem_q, rem_d;
  logic [N_W-1:0]   quot_q, quot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_W-1:0]   quotient_q, quotient_d;
  logic [D_W-1:0]   remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [D_W:0]     step_rem_s;
  logic             step_q_s;

  div_step #(.D_W(D_W)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dividend_q[N_W-1]),
    .divisor (divisor_q),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  // FSM next state and datapath; visible results only change when entering DONE.
  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          rem_d      = {(D_W + 1){1'b0}};
          quot_d     = {N_W{1'b0}};
          cnt_d      = {CNT_W{1'b0}};
          if (divisor == {D_W{1'b0}}) begin
            state_d     = DONE;
            quotient_d  = {N_W{1'b1}};
            remainder_d = dividend[D_W-1:0];
            dbz_d       = 1'b1;
          end
`ifdef DIV_EARLY_TERM_EN
          else if (dividend < N_W'(divisor)) begin
            state_d     = DONE;
            quotient_d  = {N_W{1'b0}};
            remainder_d = dividend[D_W-1:0];
            dbz_d       = 1'b0;
          end
`endif
          else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        dividend_d = {dividend_q[N_W-2:0], 1'b0};
        rem_d      = step_rem_s;
        quot_d     = {quot_q[N_W-2:0], step_q_s};
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          quotient_d  = {quot_q[N_W-2:0], step_q_s};
          remainder_d = step_rem_s[D_W-1:0];
          dbz_d       = 1'b0;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dividend_q  <= {N_W{1'b0}};
      divisor_q   <= {D_W{1'b0}};
      rem_q       <= {(D_W + 1){1'b0}};
      quot_q      <= {N_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      quotient_q  <= {N_W{1'b0}};
      remainder_q <= {D_W{1'b0}};
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_64_32.sv
// Self-checking bench for div_64_32: directed cases plus random operands against a plain-arithmetic model.
module tb_div_64_32;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int vectors;
  int miscompares;

  div_64_32 dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one operation, check latency, results, backpressure stability and return to idle.
  task automatic run_op(input logic [63:0] a, input logic [31:0] b, input int hold);
    logic [63:0] exp_q, exp_r, bz;
    logic        exp_dbz;
    int          exp_lat, lat;
    bz = {32'd0, b};
    if (b == 32'd0) begin
      exp_q = 64'hFFFF_FFFF_FFFF_FFFF; exp_r = {32'd0, a[31:0]}; exp_dbz = 1'b1; exp_lat = 1;
    end else begin
      exp_q = a / bz; exp_r = a % bz; exp_dbz = 1'b0; exp_lat = 64;
`ifdef DIV_EARLY_TERM_EN
      if (a < bz) exp_lat = 1;
`endif
    end
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom}; divisor = $urandom;
    chk("in_ready_after_accept", in_ready, 0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
    chk("latency", lat, exp_lat);
    chk("quotient", quotient, exp_q);
    chk("remainder", remainder, exp_r);
    chk("div_by_zero", div_by_zero, exp_dbz);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_quotient", quotient, exp_q);
      chk("hold_remainder", remainder, exp_r);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("quotient_kept", quotient, exp_q);
  endtask

  initial begin
    logic [63:0] ra;
    logic [31:0] rb;
    int          sel;
    vectors = 0; miscompares = 0;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = 64'd0; divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk); reset = 1'b1;

    run_op(64'd100, 32'd7, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(64'd12345, 32'd0, 0);
    run_op(64'd1000, 32'd3, 10);
    run_op(64'd5, 32'd9, 0);

    // Reset in the middle of a computation discards it.
    @(negedge clk);
    in_valid = 1'b1; dividend = 64'd100; divisor = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_quotient", quotient, 0);
    @(negedge clk); reset = 1'b1;
    run_op(64'd100, 32'd7, 0);

    for (int k = 0; k < 20; k++) begin
      ra  = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel < 4) rb = 32'($urandom_range(1, 1000));
      else rb = $urandom;
      if ($urandom_range(0, 4) == 0) ra = 64'($urandom_range(0, 50));
      run_op(ra, rb, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
